// File: rtl/cordic_disp_pkg.sv
// Shared types and constants for the CORDIC multiplier dispatcher.
package cordic_disp_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam logic [2*DATA_W_DEF-1:0] TIMEOUT_SENTINEL = 16'h8000;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD,
        GAP
    } disp_state_t;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] x;
        logic [DATA_W_DEF-1:0] z;
    } operand_pair_t;

endpackage

// File: rtl/cordic_operand_fifo.sv
// Synchronous operand FIFO; DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module cordic_operand_fifo
    import cordic_disp_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter type         item_t = operand_pair_t
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push,
    input  item_t wdata,
    input  logic  pop,
    output item_t rdata,
    output logic  full,
    output logic  empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    item_t           mem_q [DEPTH];
    logic            do_push, do_pop;

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    // Push is gated on the registered full flag, so a same-cycle pop never frees a slot.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/cordic_mul_dispatcher.sv
// Issue stage for the approximate CORDIC multiplier: operand FIFO, start/done sequencing, result stream.
// Optional WAIT timeout with sticky error flag is enabled by defining CORDIC_DISP_TIMEOUT_EN.
module cordic_mul_dispatcher
    import cordic_disp_pkg::*;
#(
    parameter int unsigned DATA_W         = DATA_W_DEF,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_x,
    input  logic [DATA_W-1:0]   in_z,
    output logic                mul_start,
    output logic [DATA_W-1:0]   mul_x,
    output logic [DATA_W-1:0]   mul_z,
    input  logic [2*DATA_W-1:0] mul_y,
    input  logic                mul_done,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*DATA_W-1:0] out_y,
    output logic [DATA_W-1:0]   out_x,
    output logic [DATA_W-1:0]   out_z,
    output logic                busy,
    output logic                timeout_err
);

    localparam int unsigned GapW = $clog2(GAP_CYCLES + 2);

    typedef struct packed {
        logic [DATA_W-1:0] x;
        logic [DATA_W-1:0] z;
    } pair_t;

    pair_t               fifo_wdata, fifo_head;
    logic                fifo_full, fifo_empty, fifo_pop;
    disp_state_t         state_q, state_d;
    logic [DATA_W-1:0]   mul_x_q, mul_x_d, mul_z_q, mul_z_d;
    logic [DATA_W-1:0]   out_x_q, out_x_d, out_z_q, out_z_d;
    logic [2*DATA_W-1:0] out_y_q, out_y_d;
    logic                out_valid_q, out_valid_d;
    logic                armed_q, armed_d;
    logic [GapW-1:0]     gap_cnt_q, gap_cnt_d;

`ifdef CORDIC_DISP_TIMEOUT_EN
    localparam int unsigned WaitW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [2*DATA_W-1:0] Sentinel = {1'b1, {(2*DATA_W-1){1'b0}}};

    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_err_q, timeout_err_d;
`endif

    assign fifo_wdata = {in_x, in_z};

    cordic_operand_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .item_t (pair_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        mul_x_d     = mul_x_q;
        mul_z_d     = mul_z_q;
        out_x_d     = out_x_q;
        out_z_d     = out_z_q;
        out_y_d     = out_y_q;
        out_valid_d = out_valid_q;
        armed_d     = armed_q;
        gap_cnt_d   = gap_cnt_q;
        fifo_pop    = 1'b0;
`ifdef CORDIC_DISP_TIMEOUT_EN
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    mul_x_d  = fifo_head.x;
                    mul_z_d  = fifo_head.z;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                armed_d = 1'b0;
`ifdef CORDIC_DISP_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
                state_d = WAIT;
            end
            WAIT: begin
                // Done only counts after it has been seen low, so a level left over
                // from the previous operation cannot be captured.
                if (armed_q && mul_done) begin
                    out_y_d     = mul_y;
                    out_x_d     = mul_x_q;
                    out_z_d     = mul_z_q;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end
`ifdef CORDIC_DISP_TIMEOUT_EN
                else if (wait_cnt_q == WaitW'(TIMEOUT_CYCLES - 1)) begin
                    out_y_d       = Sentinel;
                    out_x_d       = mul_x_q;
                    out_z_d       = mul_z_q;
                    out_valid_d   = 1'b1;
                    timeout_err_d = 1'b1;
                    state_d       = HOLD;
                end
`endif
                else begin
                    if (!mul_done) armed_d = 1'b1;
`ifdef CORDIC_DISP_TIMEOUT_EN
                    wait_cnt_d = wait_cnt_q + WaitW'(1);
`endif
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (GAP_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        gap_cnt_d = GapW'(GAP_CYCLES);
                        state_d   = GAP;
                    end
                end
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q - GapW'(1);
                if (gap_cnt_q <= GapW'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mul_x_q     <= '0;
            mul_z_q     <= '0;
            out_x_q     <= '0;
            out_z_q     <= '0;
            out_y_q     <= '0;
            out_valid_q <= 1'b0;
            armed_q     <= 1'b0;
            gap_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            mul_x_q     <= mul_x_d;
            mul_z_q     <= mul_z_d;
            out_x_q     <= out_x_d;
            out_z_q     <= out_z_d;
            out_y_q     <= out_y_d;
            out_valid_q <= out_valid_d;
            armed_q     <= armed_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

`ifdef CORDIC_DISP_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign in_ready  = !fifo_full;
    assign mul_start = (state_q == ISSUE);
    assign mul_x     = mul_x_q;
    assign mul_z     = mul_z_q;
    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;
    assign out_x     = out_x_q;
    assign out_z     = out_z_q;
    assign busy      = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_cordic_mul_dispatcher.sv
// Self-checking bench for cordic_mul_dispatcher with a behavioural multiplier stub and scoreboard.
module tb_cordic_mul_dispatcher;

    localparam int GAP = 2;

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  z;
        logic [15:0] y;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_x = '0;
    logic [7:0]  in_z = '0;
    logic        mul_start;
    logic [7:0]  mul_x, mul_z;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_y;
    logic [7:0]  out_x, out_z;
    logic        busy, timeout_err;

    int n_cmp = 0;
    int n_err = 0;
    int n_out = 0;
    bit sb_timeout = 0;
    vec_t sb_q[$];
    vec_t sb_e;
    vec_t vecs[5];

    // Multiplier stub state
    logic [15:0] stub_y = '0;
    logic        stub_done = 1'b0;
    logic [15:0] pend_y = '0;
    int          hold_left = 0;
    int          lat_left = 0;
    bit          active = 0;
    int          stub_lat = 10;
    int          stub_stale = 0;
    bit          stub_rand = 0;
    bit          stub_never = 0;

    always #5 clk = ~clk;

    cordic_mul_dispatcher dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_x        (in_x),
        .in_z        (in_z),
        .mul_start   (mul_start),
        .mul_x       (mul_x),
        .mul_z       (mul_z),
        .mul_y       (stub_y),
        .mul_done    (stub_done),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_y       (out_y),
        .out_x       (out_x),
        .out_z       (out_z),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p[15:0];
    endfunction

    function automatic logic [7:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 8'h80;
            1:       return 8'h7F;
            2:       return 8'h00;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Level-based multiplier: drops done on start (unless holding a stale done), raises it later.
    always @(posedge clk) begin
        if (mul_start) begin
            pend_y    <= ref_mul(mul_x, mul_z);
            hold_left <= stub_stale;
            lat_left  <= stub_rand ? int'($urandom_range(1, 12)) : stub_lat;
            active    <= 1'b1;
            if (stub_stale == 0) stub_done <= 1'b0;
        end else if (active) begin
            if (hold_left > 0) begin
                hold_left <= hold_left - 1;
                if (hold_left == 1) stub_done <= 1'b0;
            end else if (lat_left > 1) begin
                lat_left <= lat_left - 1;
            end else begin
                active <= 1'b0;
                if (!stub_never) begin
                    stub_done <= 1'b1;
                    stub_y    <= pend_y;
                end
            end
        end
    end

    // Scoreboard: every accepted operand pair must come back, in order, with its product.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready)
                sb_q.push_back('{x: in_x, z: in_z, y: sb_timeout ? 16'h8000 : ref_mul(in_x, in_z)});
            if (out_valid && out_ready) begin
                n_out++;
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_out", 32'd1, 32'd0);
                end else begin
                    sb_e = sb_q.pop_front();
                    check("sb_y", out_y, sb_e.y);
                    check("sb_x", out_x, sb_e.x);
                    check("sb_z", out_z, sb_e.z);
                end
            end
        end
    end

    task automatic push_one(input logic [7:0] x, input logic [7:0] z);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_x     = x;
        in_z     = z;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 300);
        check("push_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!out_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, out_valid, 1);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || out_valid || sb_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(name, busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dn, ov, cnt, bad, starts, sent, out0;
        logic [15:0] y0;

        vecs[0] = '{x: 8'h05, z: 8'hF9, y: 16'hFFDD};
        vecs[1] = '{x: 8'h7F, z: 8'h7F, y: 16'h3F01};
        vecs[2] = '{x: 8'h80, z: 8'h80, y: 16'h4000};
        vecs[3] = '{x: 8'h80, z: 8'h7F, y: 16'hC080};
        vecs[4] = '{x: 8'h00, z: 8'h63, y: 16'h0000};

        // Reset state
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_mul_start", mul_start, 0);
        check("rst_busy", busy, 0);
        check("rst_out_y", out_y, 0);
        check("rst_timeout_err", timeout_err, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;

        // Table-driven single operations; the first also checks start/valid timing
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            push_one(vecs[i].x, vecs[i].z);
            if (i == 0) begin
                @(negedge clk);
                check("lat_start_c1", mul_start, 0);
                @(negedge clk);
                check("lat_start_c2", mul_start, 1);
                @(negedge clk);
                check("start_pulse_width", mul_start, 0);
                dn = -1;
                ov = -1;
                for (int k = 1; k <= 100; k++) begin
                    @(negedge clk);
                    if (dn < 0 && stub_done) dn = k;
                    if (out_valid) begin
                        ov = k;
                        break;
                    end
                end
                check("done_to_valid", ov - dn, 1);
            end else begin
                wait_valid("vec_valid");
            end
            check("vec_out_y", out_y, vecs[i].y);
            check("vec_out_x", out_x, vecs[i].x);
            check("vec_out_z", out_z, vecs[i].z);
            wait_idle("vec_idle");
        end

        // Fill: five back-to-back pushes with the consumer stalled
        out_ready = 1'b0;
        out0 = n_out;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_x = vecs[k].x;
            in_z = vecs[k].z;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("fill_in_ready_low", in_ready, 0);
        check("fill_busy", busy, 1);
        wait_valid("fill_first_valid");
        check("fill_hold_in_ready", in_ready, 0);
        check("fill_first_y", out_y, vecs[0].y);
        in_valid = 1'b1;
        in_x = 8'h09;
        in_z = 8'h09;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (in_ready) bad++;
        end
        in_valid = 1'b0;
        check("fill_blocked_push", bad, 0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_idle("fill_drain_idle");
        check("fill_result_count", n_out - out0, 5);

        // Backpressure: result stable, no new start until handoff + gap
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        push_one(8'h03, 8'h04);
        wait_valid("bp_valid");
        y0 = out_y;
        check("bp_y", y0, 16'h000C);
        @(posedge clk);
        #1;
        push_one(8'h02, 8'h02);
        bad = 0;
        starts = 0;
        repeat (20) begin
            @(negedge clk);
            if (!out_valid || out_y !== y0) bad++;
            if (mul_start) starts++;
        end
        check("bp_stable", bad, 0);
        check("bp_no_start", starts, 0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!mul_start && cnt < 20);
        check("bp_restart_gap", cnt, GAP + 2);
        wait_idle("bp_idle");

        // Stale done: previous done stays high for a few cycles after start
        stub_stale = 3;
        @(posedge clk);
        #1;
        push_one(8'h07, 8'hFD);
        wait_valid("stale_valid");
        check("stale_new_product", out_y, 16'hFFEB);
        wait_idle("stale_idle");
        stub_stale = 0;

        // Reset in the middle of WAIT, with one more pair queued
        @(posedge clk);
        #1;
        push_one(8'h0B, 8'h0C);
        cnt = 0;
        while (!mul_start && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        @(posedge clk);
        #1;
        push_one(8'h0D, 8'h0E);
        #1 rst = 1'b1;
        sb_q.delete();
        #1;
        check("mrst_out_valid", out_valid, 0);
        check("mrst_out_y", out_y, 0);
        check("mrst_mul_x", mul_x, 0);
        check("mrst_out_x", out_x, 0);
        check("mrst_in_ready", in_ready, 1);
        check("mrst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid || mul_start) bad++;
        end
        check("mrst_late_done_ignored", bad, 0);

        // Randomized traffic with random multiplier latency and consumer stalls
        stub_rand = 1;
        sent = 0;
        cnt = 0;
        while (sent < 40 && cnt < 6000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_x      = pick_operand();
            in_z      = pick_operand();
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1;
            cnt++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("rand_sent", sent, 40);
        wait_idle("rand_idle");
        check("rand_sb_empty", sb_q.size(), 0);
        stub_rand = 0;

`ifdef CORDIC_DISP_TIMEOUT_EN
        // Timeout: multiplier never answers
        stub_never = 1;
        sb_timeout = 1;
        @(posedge clk);
        #1;
        push_one(8'h06, 8'h06);
        sb_timeout = 0;
        cnt = 0;
        while (!out_valid && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check("to_valid", out_valid, 1);
        check("to_sentinel", out_y, 16'h8000);
        check("to_err", timeout_err, 1);
        check("to_echo_x", out_x, 8'h06);
        check("to_latency_ok", (cnt >= 64 && cnt <= 70), 1);
        wait_idle("to_idle");
        stub_never = 0;
        @(posedge clk);
        #1;
        push_one(8'h02, 8'h03);
        wait_valid("to_good_valid");
        check("to_good_y", out_y, 16'h0006);
        check("to_err_sticky", timeout_err, 1);
        wait_idle("to_good_idle");
        #1 rst = 1'b1;
        #2;
        check("to_err_cleared", timeout_err, 0);
        @(posedge clk);
        #1 rst = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
